mult_sequencer: RTL and testbench



---
 rtl/mult_sequencer.sv | 141 ++++++++++++++
 tb/tb_mult_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for an N-coefficient polynomial multiplier built from two
// circular shift registers and a bank of accumulators (cyclic or negacyclic).
module mult_sequencer #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic          CSR1_load,
    output logic          CSR1_en,
    output logic          CSR2_load,
    output logic          CSR2_en,
    output logic          acc_clr,
    output logic          mac_en,
    output logic          acc_neg,
    output logic [IW-1:0] idx_i,
    output logic [IW-1:0] idx_j
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          csr1_load;
        logic          csr1_en;
        logic          csr2_load;
        logic          csr2_en;
        logic          acc_clr;
        logic          mac_en;
        logic          acc_neg;
        logic [IW-1:0] idx_i;
        logic [IW-1:0] idx_j;
    } out_t;

    localparam logic [IW-1:0] LAST  = IW'(N - 1);
    localparam logic [IW:0]   N_EXT = (IW + 1)'(N);

    state_t        state_reg, state_next;
    logic [IW-1:0] i_reg, i_next;
    logic [IW-1:0] j_reg, j_next;
    logic          mode_reg, mode_next;
    out_t          out_reg, out_next;
    logic [IW:0]   sum_next;
    logic          i_last_next, j_last_next, run_next;

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        mode_next  = mode_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    mode_next  = mode;
                    i_next     = '0;
                    j_next     = '0;
                end
            end
            LOAD: begin
                state_next = RUN;
                i_next     = '0;
                j_next     = '0;
            end
            RUN: begin
                if (j_reg == LAST) begin
                    j_next = '0;
                    if (i_reg == LAST) begin
                        state_next = DONE;
                        i_next     = '0;
                    end else begin
                        i_next = i_reg + 1'b1;
                    end
                end else begin
                    j_next = j_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                i_next     = '0;
                j_next     = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming register values and registered, so
    // each output is a pure function of the current state/counter registers.
    always_comb begin
        run_next    = (state_next == RUN);
        i_last_next = (i_next == LAST);
        j_last_next = (j_next == LAST);
        sum_next    = {1'b0, i_next} + {1'b0, j_next};
        out_next           = '0;
        out_next.busy      = (state_next != IDLE);
        out_next.done      = (state_next == DONE);
        out_next.csr1_load = (state_next == LOAD);
        out_next.acc_clr   = (state_next == LOAD);
        out_next.csr1_en   = run_next && j_last_next && !i_last_next;
        out_next.csr2_load = (state_next == LOAD) || (run_next && j_last_next && !i_last_next);
        out_next.csr2_en   = run_next && !j_last_next;
        out_next.mac_en    = run_next;
        // Product terms whose result index reaches x^N wrap with a sign flip.
        out_next.acc_neg   = run_next && mode_next && (sum_next >= N_EXT);
        out_next.idx_i     = run_next ? i_next : '0;
        out_next.idx_j     = run_next ? j_next : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            mode_reg  <= 1'b0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            mode_reg  <= mode_next;
            out_reg   <= out_next;
        end
    end

    assign busy      = out_reg.busy;
    assign done      = out_reg.done;
    assign CSR1_load = out_reg.csr1_load;
    assign CSR1_en   = out_reg.csr1_en;
    assign CSR2_load = out_reg.csr2_load;
    assign CSR2_en   = out_reg.csr2_en;
    assign acc_clr   = out_reg.acc_clr;
    assign mac_en    = out_reg.mac_en;
    assign acc_neg   = out_reg.acc_neg;
    assign idx_i     = out_reg.idx_i;
    assign idx_j     = out_reg.idx_j;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: three instances (N=4, N=2, N=5), expected
// per-operation pulse counts and timing queued by stimulus, checked at each done.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [2:0] st;
    logic [2:0] o_busy, o_done, o_c1ld, o_c1en, o_c2ld, o_c2en, o_clr, o_mac, o_neg;
    logic [7:0] o_i [3];
    logic [7:0] o_j [3];
    longint     cyc = 0;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_u
            localparam int NI = (gi == 0) ? 4 : ((gi == 1) ? 2 : 5);
            localparam int WI = $clog2(NI);
            logic [WI-1:0] ii, jj;
            logic b, d, c1l, c1e, c2l, c2e, clr, mac, neg;
            mult_sequencer #(.N(NI)) u_dut (
                .clk(clk), .reset(rst), .start(st[gi]), .mode(mode),
                .busy(b), .done(d), .CSR1_load(c1l), .CSR1_en(c1e),
                .CSR2_load(c2l), .CSR2_en(c2e), .acc_clr(clr), .mac_en(mac),
                .acc_neg(neg), .idx_i(ii), .idx_j(jj)
            );
            assign o_busy[gi] = b;
            assign o_done[gi] = d;
            assign o_c1ld[gi] = c1l;
            assign o_c1en[gi] = c1e;
            assign o_c2ld[gi] = c2l;
            assign o_c2en[gi] = c2e;
            assign o_clr[gi]  = clr;
            assign o_mac[gi]  = mac;
            assign o_neg[gi]  = neg;
            assign o_i[gi]    = 8'(ii);
            assign o_j[gi]    = 8'(jj);
        end
    endgenerate

    typedef struct {
        int          unit;
        longint      done_cyc;
        int          run, c1ld, c1en, c2ld, c2en, clr, neg, maxi, maxj;
        logic [63:0] mask;
    } exp_t;
    exp_t exp_q[$];

    function automatic int n_of(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 2 : 5);
    endfunction

    function automatic logic [24:0] outs(input int u);
        return {o_busy[u], o_done[u], o_c1ld[u], o_c1en[u], o_c2ld[u], o_c2en[u],
                o_clr[u], o_mac[u], o_neg[u], o_i[u], o_j[u]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: accumulate per-operation observations, compare at each done.
    int          a_run, a_c1ld, a_c1en, a_c2ld, a_c2en, a_clr, a_neg, a_maxi, a_maxj;
    int          a_idxbad, a_coinc;
    logic [63:0] a_mask;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_c1ld[sel]) begin
                a_run = 0; a_c1ld = 0; a_c1en = 0; a_c2ld = 0; a_c2en = 0; a_clr = 0;
                a_neg = 0; a_maxi = 0; a_maxj = 0; a_idxbad = 0; a_coinc = 0; a_mask = '0;
            end
            a_c1ld += int'(o_c1ld[sel]);
            a_c1en += int'(o_c1en[sel]);
            a_c2ld += int'(o_c2ld[sel]);
            a_c2en += int'(o_c2en[sel]);
            a_clr  += int'(o_clr[sel]);
            if (o_c1en[sel] != (o_c2ld[sel] && o_mac[sel])) a_coinc++;
            if (o_mac[sel]) begin
                a_run++;
                if (int'(o_i[sel]) > a_maxi) a_maxi = int'(o_i[sel]);
                if (int'(o_j[sel]) > a_maxj) a_maxj = int'(o_j[sel]);
                if (o_neg[sel]) begin
                    int pos;
                    pos = int'(o_i[sel]) * n_of(sel) + int'(o_j[sel]);
                    a_neg++;
                    if (pos < 64) a_mask[pos] = 1'b1;
                end
            end else if (o_i[sel] != 8'd0 || o_j[sel] != 8'd0 || o_neg[sel]) begin
                a_idxbad++;
            end
            if (o_done[sel]) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn unit=%0d N=%0d done at cycle %0d run=%0d neg=%0d",
                             sel, n_of(sel), cyc, a_run, a_neg);
                    chk("unit", sel, e.unit);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("run_len", a_run, e.run);
                    chk("csr1_load_cnt", a_c1ld, e.c1ld);
                    chk("csr1_en_cnt", a_c1en, e.c1en);
                    chk("csr2_load_cnt", a_c2ld, e.c2ld);
                    chk("csr2_en_cnt", a_c2en, e.c2en);
                    chk("acc_clr_cnt", a_clr, e.clr);
                    chk("acc_neg_cnt", a_neg, e.neg);
                    chk("acc_neg_mask", longint'(a_mask), longint'(e.mask));
                    chk("max_idx_i", a_maxi, e.maxi);
                    chk("max_idx_j", a_maxj, e.maxj);
                    chk("idx_outside_run", a_idxbad, 0);
                    chk("csr1en_csr2load_coincide", a_coinc, 0);
                end
            end
        end
    end

    task automatic push_exp(input int u, input longint dc, input int run, input int c1en,
                            input int c2ld, input int c2en, input int neg,
                            input logic [63:0] mask, input int maxn);
        exp_t e;
        e.unit = u; e.done_cyc = dc; e.run = run; e.c1ld = 1; e.c1en = c1en;
        e.c2ld = c2ld; e.c2en = c2en; e.clr = 1; e.neg = neg; e.mask = mask;
        e.maxi = maxn; e.maxj = maxn;
        exp_q.push_back(e);
    endtask

    task automatic wait_dones(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("done_seen", done_cnt, target);
    endtask

    // Single start pulse on unit u; done expected N*N+2 cycles after the sampling edge.
    task automatic issue(input int u, input logic m, input int run, input int c1en,
                         input int c2ld, input int c2en, input int neg,
                         input logic [63:0] mask, input int maxn);
        @(negedge clk);
        sel = u;
        mode = m;
        st[u] = 1'b1;
        push_exp(u, cyc + run + 2, run, c1en, c2ld, c2en, neg, mask, maxn);
        @(negedge clk);
        st[u] = 1'b0;
    endtask

    initial begin
        int base;
        longint c;
        rst = 1'b1;
        st = 3'b000;
        mode = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk("reset_outputs_zero", longint'(outs(u)), 0);
        rst = 1'b0;

        // N=4 cyclic
        base = done_cnt;
        issue(0, 1'b0, 16, 3, 4, 12, 0, 64'h0, 3);
        wait_dones(base + 1);

        // N=4 negacyclic, mode toggled while running
        base = done_cnt;
        issue(0, 1'b1, 16, 3, 4, 12, 6, 64'hEC80, 3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mode = ~mode;
        end
        wait_dones(base + 1);

        // start held high: back-to-back operations 19 cycles apart
        base = done_cnt;
        @(negedge clk);
        sel = 0;
        mode = 1'b0;
        st[0] = 1'b1;
        push_exp(0, cyc + 18, 16, 3, 4, 12, 0, 64'h0, 3);
        push_exp(0, cyc + 37, 16, 3, 4, 12, 0, 64'h0, 3);
        repeat (20) @(negedge clk);
        st[0] = 1'b0;
        wait_dones(base + 2);

        // reset at the 7th RUN cycle aborts without done
        base = done_cnt;
        @(negedge clk);
        sel = 0;
        st[0] = 1'b1;
        c = cyc;
        @(negedge clk);
        st[0] = 1'b0;
        while (cyc < c + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", longint'(o_busy[0]), 0);
        chk("abort_outputs_zero", longint'(outs(0)), 0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_no_done", done_cnt, base);
        issue(0, 1'b0, 16, 3, 4, 12, 0, 64'h0, 3);
        wait_dones(base + 1);

        // N=2 negacyclic: only (1,1) wraps
        base = done_cnt;
        issue(1, 1'b1, 4, 1, 2, 2, 1, 64'h8, 1);
        wait_dones(base + 1);

        // N=5 negacyclic: ten wrapping pairs
        base = done_cnt;
        issue(2, 1'b1, 25, 4, 5, 20, 10, 64'h01EE6200, 4);
        wait_dones(base + 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
